// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and sequencer for a 256-word data memory
// Ports: clk, rst_n (async active-low);
//        p0_*/p1_* requester req/we/addr/wdata in, gnt/rvalid/rdata/err out;
//        mem_address/mem_read/mem_write/mem_write_data out, mem_read_data in; busy out.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p0_err,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t            r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_we;
    logic              r_err;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              w_any;
    logic              w_p1_win;
    logic              w_grant;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_in_range;
    logic              w_resp;
    logic [DATA_W-1:0] w_rdata;
    assign w_any      = p0_req | p1_req;
    // p1 wins when alone, or on a tie when p0 was granted last
    assign w_p1_win   = p1_req & (~p0_req | ~r_last);
    // gnt is combinational, so it is gated by reset to keep outputs quiet while held
    assign w_grant    = rst_n & (r_state == IDLE) & w_any;
    assign w_we       = w_p1_win ? p1_we : p0_we;
    assign w_addr     = w_p1_win ? p1_addr : p0_addr;
    assign w_wdata    = w_p1_win ? p1_wdata : p0_wdata;
    assign w_in_range = w_addr[ADDR_W-1:DEPTH_LOG2] == '0;
    assign w_resp     = r_state == RESP;
    assign w_rdata    = (w_resp & ~r_we & ~r_err) ? mem_read_data : '0;
    assign p0_gnt     = w_grant & ~w_p1_win;
    assign p1_gnt     = w_grant & w_p1_win;
    assign p0_rvalid  = w_resp & ~r_owner;
    assign p1_rvalid  = w_resp & r_owner;
    assign p0_rdata   = p0_rvalid ? w_rdata : '0;
    assign p1_rdata   = p1_rvalid ? w_rdata : '0;
    assign p0_err     = p0_rvalid & r_err;
    assign p1_err     = p1_rvalid & r_err;
    assign busy       = r_state != IDLE;
    assign mem_address    = r_mem_address;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_write_data = r_mem_wdata;
    // The memory registers double as the latched addr/wdata: they are loaded on
    // the grant edge and cleared on every other edge, so they live only in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last        <= 1'b1;
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_err         <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_p1_win;
                        r_last  <= w_p1_win;
                        r_we    <= w_we;
                        r_err   <= ~w_in_range;
                        r_state <= w_in_range ? ACCESS : RESP;
                        if (w_in_range) begin
                            r_mem_address <= w_addr;
                            r_mem_read    <= ~w_we;
                            r_mem_write   <= w_we;
                            r_mem_wdata   <= w_wdata;
                        end
                    end
                end
                ACCESS:  r_state <= RESP;
                default: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule
